up_counter_ctrl: RTL
====================

Name: up_counter_ctrl

Overview:
Control stage placed directly upstream of the team's 8-bit synchronous up counter. It drives the counter's enable and synchronous clear inputs, and reads the counter's output back as feedback. This turns the counter into a programmable timer with a clock prescaler, a terminal count, one-shot and periodic modes, and start/stop commands. Two outputs feed the counter: cnt_enable goes to the counter's enable, and cnt_clear goes to its reset. The counter's output connects back to count_in.

Parameters:
WIDTH, 8, width of the count feedback and the terminal value; matches the counter output width.
PS_WIDTH, 8, width of the prescale value and the internal prescaler.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  start command; sampled on the rising edge of clk
stop  in  1  stop command; sampled on the rising edge of clk
periodic  in  1  mode select: 1 = periodic, 0 = one-shot; latched on start
prescale  in  PS_WIDTH  tick every prescale+1 clocks; latched on start
terminal  in  WIDTH  terminal count; latched on start
count_in  in  WIDTH  counter output (feedback)
cnt_enable  out  1  counter enable; combinational
cnt_clear  out  1  counter synchronous clear; combinational
busy  out  1  high in ARM or RUN
done  out  1  one-cycle registered pulse, asserted in the cycle after each terminal event
expired  out  1  high in the DONE state

Behaviour:
- Interface: single clock domain, clk. reset is asynchronous and active-high.
- While reset is high:
  - state = IDLE; prescaler = 0; latched prescale, terminal and mode = 0.
  - done = 0, busy = 0, expired = 0, cnt_enable = 0.
  - cnt_clear = 1, so the counter is cleared on any clock edge that occurs during reset.
- States: IDLE, ARM, RUN, DONE.
- IDLE:
  - Outputs: cnt_enable = 0, cnt_clear = 0.
  - start = 1 and stop = 0: latch prescale, terminal and periodic, then go to ARM.
- ARM (lasts exactly one cycle):
  - cnt_clear = 1, cnt_enable = 0, prescaler <= 0.
  - Next state is RUN.
- RUN:
  - tick = (prescaler == latched prescale).
  - On tick the prescaler returns to 0; otherwise it increments.
  - With prescale = 0, tick is asserted every cycle.
- Terminal event: tick is high and count_in == latched terminal.
- On a tick with no terminal event: cnt_enable = 1 for that cycle.
- On a terminal event:
  - cnt_enable = 0.
  - done is asserted in the following cycle.
  - One-shot mode: go to DONE. The counter holds the terminal value.
  - Periodic mode: cnt_clear = 1 in the same cycle and the block stays in RUN.
- Timing consequences:
  - The counter value after each enable is visible in the next cycle. cnt_enable and cnt_clear are Mealy outputs of registered state and count_in, so there is no extra latency.
  - Periodic mode: period = (terminal+1)*(prescale+1) clocks.
  - terminal = 0: the first tick is already a terminal event.
- DONE:
  - expired = 1.
  - start: relatch the inputs and go to ARM.
  - stop: go to IDLE.
- stop in ARM, RUN or DONE:
  - Next state is IDLE.
  - In that cycle cnt_enable = 0, cnt_clear = 0, and no done pulse is produced.
  - The counter keeps its value.
- Priority and ignored commands:
  - start and stop in the same cycle: stop wins.
  - start while in ARM or RUN is ignored. Latched values cannot change mid-run.
- Input changes: changes on prescale, terminal or periodic outside the start cycle have no effect.
- Arithmetic and width:
  - All comparisons are unsigned equality.
  - The prescaler is PS_WIDTH bits and never exceeds the latched prescale.
- Asserting reset mid-run aborts immediately, with the reset values listed above.

Test Plan:
- One-shot: prescale=1, terminal=3; pulse start.
  - Required: one ARM cycle with cnt_clear; then cnt_enable on ticks 1-3, 2 clocks apart; count 0→1→2→3.
  - On the 4th tick: no enable, done pulses once, expired=1, count holds 3.
- Periodic: prescale=0, terminal=4.
  - Required: count sequence 0,1,2,3,4,0,1,...; cnt_clear and done every 5 clocks; busy stays 1.
- terminal=0, prescale=2, periodic.
  - Required: cnt_enable never asserts; cnt_clear and done every 3 clocks.
- Stop mid-run: prescale=0, terminal=200; stop when count=10.
  - Required: next state IDLE, count stays 10, busy=0, no done pulse. A later start reclears the count to 0.
- Same-cycle start+stop in IDLE: stays IDLE.
  - start while in RUN with a different terminal: ignored; the original terminal is still honoured.
- Asynchronous reset asserted mid-cycle during RUN.
  - Required: all outputs go to their reset values without waiting for a clock edge. cnt_clear=1 and the counter reads 0 after the next edge.

Source files
------------

// File: rtl/up_counter_ctrl_if.sv
// Signal bundle between the timer control stage and its host/counter side.
// The slave modport is the control stage; the master modport drives commands and count feedback.
interface up_counter_ctrl_if #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 8
);
    logic                start;
    logic                stop;
    logic                periodic;
    logic [PS_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]    terminal;
    logic [WIDTH-1:0]    count_in;
    logic                cnt_enable;
    logic                cnt_clear;
    logic                busy;
    logic                done;
    logic                expired;

    modport master (
        output start, stop, periodic, prescale, terminal, count_in,
        input  cnt_enable, cnt_clear, busy, done, expired
    );

    modport slave (
        input  start, stop, periodic, prescale, terminal, count_in,
        output cnt_enable, cnt_clear, busy, done, expired
    );
endinterface

// File: rtl/up_counter_ctrl.sv
// Programmable timer control wrapped around an external 8-bit up counter:
// prescaler, terminal count, one-shot/periodic modes and start/stop commands.
module up_counter_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    up_counter_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [PS_WIDTH-1:0] PS_ONE = {{(PS_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_q,     state_d;
    logic [PS_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [PS_WIDTH-1:0] ps_lat_q,    ps_lat_d;
    logic [WIDTH-1:0]    term_lat_q,  term_lat_d;
    logic                per_lat_q,   per_lat_d;
    logic                done_q,      done_d;

    logic tick;
    logic term_evt;
    logic do_latch;
    logic cnt_enable_d;
    logic cnt_clear_d;

    assign tick     = (state_q == S_RUN) && (prescaler_q == ps_lat_q);
    assign term_evt = tick && (bus.count_in == term_lat_q);

    always_comb begin
        state_d      = state_q;
        prescaler_d  = '0;
        done_d       = 1'b0;
        cnt_enable_d = 1'b0;
        cnt_clear_d  = 1'b0;
        do_latch     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    do_latch = 1'b1;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_clear_d = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else begin
                    prescaler_d = tick ? '0 : (prescaler_q + PS_ONE);
                    if (term_evt) begin
                        // Periodic restarts by clearing the counter in the terminal cycle itself
                        done_d = 1'b1;
                        if (per_lat_q) begin
                            cnt_clear_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (tick) begin
                        cnt_enable_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    do_latch = 1'b1;
                    state_d  = S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ps_lat_d   = do_latch ? bus.prescale : ps_lat_q;
        term_lat_d = do_latch ? bus.terminal : term_lat_q;
        per_lat_d  = do_latch ? bus.periodic : per_lat_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prescaler_q <= '0;
            ps_lat_q    <= '0;
            term_lat_q  <= '0;
            per_lat_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            ps_lat_q    <= ps_lat_d;
            term_lat_q  <= term_lat_d;
            per_lat_q   <= per_lat_d;
            done_q      <= done_d;
        end
    end

    // Clear is forced while reset is held so the counter zeroes on any edge during reset
    assign bus.cnt_clear  = cnt_clear_d | reset;
    assign bus.cnt_enable = cnt_enable_d & ~reset;
    assign bus.busy       = (state_q == S_ARM) || (state_q == S_RUN);
    assign bus.expired    = (state_q == S_DONE);
    assign bus.done       = done_q;
endmodule
